// File: rtl/sum_accumulator.sv
// sum_accumulator
//   Collects NSAMP unsigned sums from the adder stage over a valid/ready
//   handshake and presents one frame result at a time: the frame total
//   (modulo 2^AWIDTH), the count of samples flagged zero, and a sticky
//   carry-out flag. The result is held until downstream accepts it. While
//   the result is held, no new samples are taken. This costs one bubble
//   per frame.
//
// Ports
//   i_clk        clock, all logic on posedge
//   i_rst        synchronous reset, active-high
//   i_clear      flush the partial frame (ignored while a result is held)
//   i_in_valid   input sample valid
//   o_in_ready   accumulator can take a sample (state-derived only)
//   i_in_sum     sample value, unsigned, SWIDTH bits
//   i_in_zero    sample-is-zero flag, used exactly as supplied
//   o_out_valid  frame result valid
//   i_out_ready  downstream accepts the result
//   o_out_sum    frame total, AWIDTH bits
//   o_out_zcnt   number of accepted samples with i_in_zero=1
//   o_out_ovf    a carry out of AWIDTH occurred during the frame
module sum_accumulator #(
  parameter int SWIDTH = 9,
  parameter int NSAMP  = 4,
  parameter int AWIDTH = SWIDTH + $clog2(NSAMP),
  parameter int CWIDTH = $clog2(NSAMP + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [SWIDTH-1:0] i_in_sum,
  input  logic              i_in_zero,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [AWIDTH-1:0] o_out_sum,
  output logic [CWIDTH-1:0] o_out_zcnt,
  output logic              o_out_ovf
);

  typedef enum logic {ACC, HOLD} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [AWIDTH-1:0]   r_acc;
  logic [CWIDTH-1:0]   r_cnt;
  logic [CWIDTH-1:0]   r_zcnt;
  logic                r_ovf;
  logic [AWIDTH-1:0]   r_out_sum;
  logic [CWIDTH-1:0]   r_out_zcnt;
  logic                r_out_ovf;

  logic                w_in_ready;
  logic                w_out_valid;
  logic                w_accept;
  logic                w_last;
  logic [AWIDTH:0]     w_sum_ext;   // one extra bit to catch the carry out
  logic [CWIDTH-1:0]   w_zcnt_nxt;
  logic                w_ovf_nxt;

  // Sample arithmetic, using the updated values so the final sample lands in
  // the presented result.
  assign w_sum_ext  = {1'b0, r_acc} + (AWIDTH+1)'(i_in_sum);
  assign w_zcnt_nxt = r_zcnt + CWIDTH'(i_in_zero);
  assign w_ovf_nxt  = r_ovf | w_sum_ext[AWIDTH];
  assign w_last     = (r_cnt == CWIDTH'(NSAMP - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ACC;
    else       r_state <= w_state_nxt;
  end

  // Handshake outputs depend on state only, so out_ready never reaches
  // in_ready combinationally.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ACC: begin
        w_in_ready = 1'b1;
        // A sample offered alongside clear is dropped with the partial frame.
        w_accept   = i_in_valid & ~i_clear;
        if (w_accept && w_last) w_state_nxt = HOLD;
      end
      HOLD: begin
        w_out_valid = 1'b1;
        if (i_out_ready) w_state_nxt = ACC;
      end
      default: w_state_nxt = ACC;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_zcnt     <= '0;
      r_ovf      <= 1'b0;
      r_out_sum  <= '0;
      r_out_zcnt <= '0;
      r_out_ovf  <= 1'b0;
    end else if (r_state == ACC && i_clear) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_zcnt <= '0;
      r_ovf  <= 1'b0;
    end else if (w_accept) begin
      if (w_last) begin
        r_out_sum  <= w_sum_ext[AWIDTH-1:0];
        r_out_zcnt <= w_zcnt_nxt;
        r_out_ovf  <= w_ovf_nxt;
        r_acc      <= '0;
        r_cnt      <= '0;
        r_zcnt     <= '0;
        r_ovf      <= 1'b0;
      end else begin
        r_acc  <= w_sum_ext[AWIDTH-1:0];
        r_cnt  <= r_cnt + CWIDTH'(1);
        r_zcnt <= w_zcnt_nxt;
        r_ovf  <= w_ovf_nxt;
      end
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = w_out_valid;
  assign o_out_sum   = r_out_sum;
  assign o_out_zcnt  = r_out_zcnt;
  assign o_out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_sum_accumulator.sv
module tb_sum_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // a_*: default widths (AWIDTH=11). b_*: narrow accumulator (AWIDTH=9).
  logic        a_clear, a_in_valid, a_in_ready, a_in_zero, a_out_valid, a_out_ready, a_out_ovf;
  logic [8:0]  a_in_sum;
  logic [10:0] a_out_sum;
  logic [2:0]  a_out_zcnt;

  logic        b_clear, b_in_valid, b_in_ready, b_in_zero, b_out_valid, b_out_ready, b_out_ovf;
  logic [8:0]  b_in_sum;
  logic [8:0]  b_out_sum;
  logic [2:0]  b_out_zcnt;

  sum_accumulator #(.SWIDTH(9), .NSAMP(4)) u_a (
    .i_clk(clk), .i_rst(rst), .i_clear(a_clear),
    .i_in_valid(a_in_valid), .o_in_ready(a_in_ready),
    .i_in_sum(a_in_sum), .i_in_zero(a_in_zero),
    .o_out_valid(a_out_valid), .i_out_ready(a_out_ready),
    .o_out_sum(a_out_sum), .o_out_zcnt(a_out_zcnt), .o_out_ovf(a_out_ovf)
  );

  sum_accumulator #(.SWIDTH(9), .NSAMP(4), .AWIDTH(9)) u_b (
    .i_clk(clk), .i_rst(rst), .i_clear(b_clear),
    .i_in_valid(b_in_valid), .o_in_ready(b_in_ready),
    .i_in_sum(b_in_sum), .i_in_zero(b_in_zero),
    .o_out_valid(b_out_valid), .i_out_ready(b_out_ready),
    .o_out_sum(b_out_sum), .o_out_zcnt(b_out_zcnt), .o_out_ovf(b_out_ovf)
  );

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; everything is driven and sampled 1 unit after posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input int v, input bit z);
    a_in_valid = 1'b1; a_in_sum = 9'(v); a_in_zero = z;
    tick();
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input int v, input bit z);
    b_in_valid = 1'b1; b_in_sum = 9'(v); b_in_zero = z;
    tick();
    b_in_valid = 1'b0;
  endtask

  task automatic chk_a_idle(input string tag);
    chk({tag, "_rdy"},  a_in_ready,  1);
    chk({tag, "_vld"},  a_out_valid, 0);
    chk({tag, "_sum"},  a_out_sum,   0);
    chk({tag, "_zcnt"}, a_out_zcnt,  0);
    chk({tag, "_ovf"},  a_out_ovf,   0);
  endtask

  task automatic chk_a_res(input string tag, input int s, input int z, input int o);
    chk({tag, "_vld"},  a_out_valid, 1);
    chk({tag, "_rdy"},  a_in_ready,  0);
    chk({tag, "_sum"},  a_out_sum,   s);
    chk({tag, "_zcnt"}, a_out_zcnt,  z);
    chk({tag, "_ovf"},  a_out_ovf,   o);
  endtask

  // Random-phase reference state.
  bit m_hold;
  int m_acc, m_cnt, m_zc, m_os, m_oz;
  bit r_v, r_z, r_or;
  int r_s;

  initial begin
    rst = 1'b1;
    a_clear = 0; a_in_valid = 0; a_in_sum = 0; a_in_zero = 0; a_out_ready = 1;
    b_clear = 0; b_in_valid = 0; b_in_sum = 0; b_in_zero = 0; b_out_ready = 0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk_a_idle("reset");
    chk("reset_b_rdy", b_in_ready, 1);
    chk("reset_b_vld", b_out_valid, 0);

    // 1: back-to-back 10,20,30,40 with out_ready=1
    send_a(10, 0); send_a(20, 0); send_a(30, 0);
    chk("t1_vld_early", a_out_valid, 0);
    send_a(40, 0);
    chk_a_res("t1", 100, 0, 0);
    tick();
    chk("t1_rdy_back", a_in_ready, 1);
    chk("t1_vld_drop", a_out_valid, 0);

    // 2: extremes with zero flags, result held (out_ready=0)
    a_out_ready = 0;
    send_a(0, 1); send_a(511, 0); send_a(0, 1); send_a(511, 0);
    chk_a_res("t2", 1022, 2, 0);

    // 3: hold 5 cycles with junk input and clear; result must not move
    a_in_valid = 1; a_in_sum = 9'd99; a_in_zero = 1; a_clear = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_a_res("t3_hold", 1022, 2, 0);
    end
    a_in_valid = 0; a_clear = 0; a_out_ready = 1;
    tick();
    chk("t3_rel_vld", a_out_valid, 0);
    chk("t3_rel_rdy", a_in_ready, 1);
    send_a(1, 0); send_a(1, 0); send_a(1, 0); send_a(1, 0);
    chk_a_res("t3_next", 4, 0, 0);
    tick();

    // 4: narrow accumulator wraps: 600 mod 512 = 88, ovf sticky for the frame
    send_b(300, 0); send_b(300, 0); send_b(0, 1); send_b(0, 1);
    chk("t4_vld",  b_out_valid, 1);
    chk("t4_sum",  b_out_sum,   88);
    chk("t4_zcnt", b_out_zcnt,  2);
    chk("t4_ovf",  b_out_ovf,   1);
    b_out_ready = 1;
    tick();
    send_b(1, 0); send_b(2, 0); send_b(3, 0); send_b(4, 0);
    chk("t4b_sum", b_out_sum, 10);
    chk("t4b_ovf", b_out_ovf, 0);
    tick();

    // 5: partial frame flushed by clear; the sample offered with clear is dropped
    send_a(5, 1); send_a(6, 0);
    a_clear = 1; send_a(7, 1); a_clear = 0;
    send_a(1, 0); send_a(2, 0);
    chk("t5_vld_early", a_out_valid, 0);
    send_a(3, 0); send_a(4, 0);
    chk_a_res("t5", 10, 0, 0);
    tick();

    // 6: reset while holding, then reset mid-frame
    a_out_ready = 0;
    send_a(50, 0); send_a(50, 0); send_a(50, 0); send_a(50, 0);
    chk_a_res("t6_pre", 200, 0, 0);
    rst = 1; tick(); rst = 0;
    chk_a_idle("t6_rst_hold");
    send_a(9, 1); send_a(9, 1); send_a(9, 1);
    rst = 1; tick(); rst = 0;
    chk_a_idle("t6_rst_mid");
    send_a(2, 1); send_a(4, 0); send_a(6, 0); send_a(8, 0);
    chk_a_res("t6_after", 20, 1, 0);
    a_out_ready = 1;
    tick();

    // Random valid/ready gaps against a reference model
    m_hold = 0; m_acc = 0; m_cnt = 0; m_zc = 0; m_os = 0; m_oz = 0;
    for (int c = 0; c < 300; c++) begin
      chk("rnd_rdy", a_in_ready, !m_hold);
      chk("rnd_vld", a_out_valid, m_hold);
      if (m_hold) begin
        chk("rnd_sum",  a_out_sum,  m_os);
        chk("rnd_zcnt", a_out_zcnt, m_oz);
        chk("rnd_ovf",  a_out_ovf,  0);
      end
      r_v  = ($urandom_range(0, 3) != 0);
      r_s  = $urandom_range(0, 511);
      r_z  = $urandom_range(0, 1);
      r_or = ($urandom_range(0, 2) != 0);
      a_in_valid = r_v; a_in_sum = 9'(r_s); a_in_zero = r_z; a_out_ready = r_or;
      if (!m_hold) begin
        if (r_v) begin
          m_acc += r_s; m_zc += r_z; m_cnt++;
          if (m_cnt == 4) begin
            m_os = m_acc; m_oz = m_zc; m_hold = 1;
            m_acc = 0; m_zc = 0; m_cnt = 0;
          end
        end
      end else if (r_or) begin
        m_hold = 0;
      end
      tick();
    end
    a_in_valid = 0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
